// File: rtl/vram_pkg.sv
// Shared types and default geometry for the scrolling character video RAM.
package vram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCROLL,
    CLEAR
  } state_t;

  // Source selector for the registered read output.
  typedef enum logic [1:0] {
    RD_ZERO,
    RD_MEM,
    RD_BLANK
  } rd_src_t;

  localparam logic [5:0] BLANK_CHAR = 6'b100000;
  localparam int COLS_40 = 40;
  localparam int ROWS_24 = 24;

endpackage

// File: rtl/vram_dp_mem.sv
// Simple dual-port storage: one synchronous read port, one write port,
// read-before-write on address collision, no reset on the array.
module vram_dp_mem #(
  parameter int DATA_WIDTH   = 6,
  parameter int DEPTH        = 960,
  parameter     RAM_FILENAME = "",
  localparam int ADDR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/vram_ring.sv
// Character video RAM organised as a ring of rows: scrolling advances the
// top-row pointer and a sequencer blanks the row that becomes the bottom line.
module vram_ring
  import vram_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 6,
  parameter int                    COLS         = COLS_40,
  parameter int                    ROWS         = ROWS_24,
  parameter logic [DATA_WIDTH-1:0] BLANK        = DATA_WIDTH'(BLANK_CHAR),
  parameter                        RAM_FILENAME = "",
  localparam int                   COL_W        = $clog2(COLS),
  localparam int                   ROW_W        = $clog2(ROWS),
  localparam int                   ADDR_W       = $clog2(ROWS * COLS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r_en,
  input  logic [ROW_W-1:0]      r_row,
  input  logic [COL_W-1:0]      r_col,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  w_en,
  input  logic [ROW_W-1:0]      w_row,
  input  logic [COL_W-1:0]      w_col,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  scroll_req,
  input  logic                  clr_req,
  output logic                  busy,
  output logic [ROW_W-1:0]      top_row
);

  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(ROWS * COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [ROW_W:0]    ROWS_X    = (ROW_W + 1)'(ROWS);
  localparam logic [COL_W:0]    COLS_X    = (COL_W + 1)'(COLS);

  state_t              state_q, state_d;
  rd_src_t             rd_src_q, rd_src_d;
  logic [ROW_W-1:0]    top_row_q, top_row_d;
  // top_base tracks top_row*COLS incrementally so the sequencer needs no multiplier.
  logic [ADDR_W-1:0]   top_base_q, top_base_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   seq_addr_q, seq_addr_d;

  logic                r_in_range, w_in_range;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;

  function automatic logic [ADDR_W-1:0] map_addr(input logic [ROW_W-1:0] top,
                                                  input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    logic [ROW_W:0] phys;
    phys = {1'b0, top} + {1'b0, row};
    if (phys >= ROWS_X) phys = phys - ROWS_X;
    return ADDR_W'(phys) * COLS_A + ADDR_W'(col);
  endfunction

  assign r_in_range = ({1'b0, r_row} < ROWS_X) && ({1'b0, r_col} < COLS_X);
  assign w_in_range = ({1'b0, w_row} < ROWS_X) && ({1'b0, w_col} < COLS_X);
  assign r_addr     = map_addr(top_row_q, r_row, r_col);
  assign w_addr     = map_addr(top_row_q, w_row, w_col);

  always_comb begin
    rd_src_d = rd_src_q;
    if (r_en) rd_src_d = r_in_range ? RD_MEM : RD_BLANK;
  end

  // Sequencer owns the write port while running; reset also blocks writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = w_addr;
    mem_wdata = din;
    if (state_q != IDLE) begin
      mem_we    = 1'b1;
      mem_waddr = seq_addr_q;
      mem_wdata = BLANK;
    end else if (w_en && w_in_range) begin
      mem_we = 1'b1;
    end
    mem_we = mem_we & rst_n;
  end

  always_comb begin
    state_d    = state_q;
    top_row_d  = top_row_q;
    top_base_d = top_base_q;
    cnt_d      = cnt_q;
    seq_addr_d = seq_addr_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d    = CLEAR;
          top_row_d  = '0;
          top_base_d = '0;
          cnt_d      = '0;
          seq_addr_d = '0;
        end else if (scroll_req) begin
          state_d    = SCROLL;
          seq_addr_d = top_base_q;
          top_row_d  = (top_row_q == LAST_ROW) ? '0 : top_row_q + 1'b1;
          top_base_d = (top_base_q == LAST_BASE) ? '0 : top_base_q + COLS_A;
          cnt_d      = '0;
        end
      end
      SCROLL: begin
        cnt_d      = cnt_q + 1'b1;
        seq_addr_d = seq_addr_q + 1'b1;
        if (cnt_q == LAST_COL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d      = cnt_q + 1'b1;
        seq_addr_d = seq_addr_q + 1'b1;
        if (cnt_q == LAST_CELL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_src_q   <= RD_ZERO;
      top_row_q  <= '0;
      top_base_q <= '0;
      cnt_q      <= '0;
      seq_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_src_q   <= rd_src_d;
      top_row_q  <= top_row_d;
      top_base_q <= top_base_d;
      cnt_q      <= cnt_d;
      seq_addr_q <= seq_addr_d;
    end
  end

  vram_dp_mem #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH       (ROWS * COLS),
    .RAM_FILENAME(RAM_FILENAME)
  ) u_mem (
    .clk    (clk),
    .rd_en  (r_en && r_in_range),
    .rd_addr(r_addr),
    .rd_data(mem_rdata),
    .wr_en  (mem_we),
    .wr_addr(mem_waddr),
    .wr_data(mem_wdata)
  );

  always_comb begin
    unique case (rd_src_q)
      RD_MEM:   dout = mem_rdata;
      RD_BLANK: dout = BLANK;
      default:  dout = '0;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign top_row = top_row_q;

endmodule

// File: tb/tb_vram_ring.sv
// Directed self-checking bench for vram_ring (40x24 cells, 6-bit codes).
module tb_vram_ring;

  localparam logic [5:0] BLANK = 6'h20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       r_en = 1'b0, w_en = 1'b0, scroll_req = 1'b0, clr_req = 1'b0;
  logic [4:0] r_row = '0, w_row = '0, top_row;
  logic [5:0] r_col = '0, w_col = '0, din = '0, dout;
  logic       busy;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  vram_ring #(
    .DATA_WIDTH(6), .COLS(40), .ROWS(24), .BLANK(6'h20), .RAM_FILENAME("")
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .r_en(r_en), .r_row(r_row), .r_col(r_col), .dout(dout),
    .w_en(w_en), .w_row(w_row), .w_col(w_col), .din(din),
    .scroll_req(scroll_req), .clr_req(clr_req),
    .busy(busy), .top_row(top_row)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_cell(input int row, input int col, input logic [5:0] d);
    w_row = 5'(row); w_col = 6'(col); din = d; w_en = 1'b1;
    tick;
    w_en = 1'b0;
  endtask

  task automatic read_cell(input int row, input int col, output logic [5:0] d);
    r_row = 5'(row); r_col = 6'(col); r_en = 1'b1;
    tick;
    r_en = 1'b0;
    d = dout;
  endtask

  // Counts busy cycles, optionally injecting a write or scroll_req at a given count.
  task automatic count_busy(input int inject_w, input int inject_s, output int n);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      w_en = (n == inject_w);
      scroll_req = (n == inject_s);
      tick;
      n++;
    end
    w_en = 1'b0;
    scroll_req = 1'b0;
  endtask

  task automatic pulse_scroll;
    scroll_req = 1'b1; tick; scroll_req = 1'b0;
  endtask

  task automatic pulse_clear;
    clr_req = 1'b1; tick; clr_req = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick;
    checks++; if (dout !== 6'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (top_row !== 5'd0) begin failures++; $display("FAIL reset_top_row got=%0d exp=0", top_row); end
    rst_n = 1'b1;
    tick;
    $display("test_reset done");
  endtask

  task automatic test_read_write;
    logic [5:0] d;
    write_cell(0, 0, 6'h01);
    read_cell(0, 0, d);
    checks++; if (d !== 6'h01) begin failures++; $display("FAIL rw_read got=%h exp=01", d); end
    r_row = 5'd7;
    tick;
    checks++; if (dout !== 6'h01) begin failures++; $display("FAIL rw_hold got=%h exp=01", dout); end
    read_cell(24, 0, d);
    checks++; if (d !== BLANK) begin failures++; $display("FAIL rw_oob_row got=%h exp=20", d); end
    read_cell(0, 0, d);
    checks++; if (d !== 6'h01) begin failures++; $display("FAIL rw_reread got=%h exp=01", d); end
    read_cell(0, 40, d);
    checks++; if (d !== BLANK) begin failures++; $display("FAIL rw_oob_col got=%h exp=20", d); end
    $display("test_read_write done");
  endtask

  task automatic test_scroll;
    logic [5:0] d;
    int n;
    for (int c = 0; c < 40; c++) begin
      write_cell(0, c, 6'h05);
      write_cell(23, c, 6'h07);
    end
    pulse_scroll;
    count_busy(-1, -1, n);
    checks++; if (n != 40) begin failures++; $display("FAIL scroll_busy_len got=%0d exp=40", n); end
    checks++; if (top_row !== 5'd1) begin failures++; $display("FAIL scroll_top_row got=%0d exp=1", top_row); end
    for (int c = 0; c < 40; c++) begin
      read_cell(22, c, d);
      checks++; if (d !== 6'h07) begin failures++; $display("FAIL scroll_row22 col=%0d got=%h exp=07", c, d); end
      read_cell(23, c, d);
      checks++; if (d !== BLANK) begin failures++; $display("FAIL scroll_row23 col=%0d got=%h exp=20", c, d); end
    end
    $display("test_scroll done");
  endtask

  task automatic test_scroll_wrap;
    logic [5:0] d;
    int n;
    rst_n = 1'b0; tick; rst_n = 1'b1; tick;
    write_cell(3, 7, 6'h0A);
    write_cell(10, 39, 6'h0B);
    write_cell(0, 0, 6'h0C);
    for (int i = 0; i < 24; i++) begin
      pulse_scroll;
      count_busy(-1, -1, n);
      checks++; if (n != 40) begin failures++; $display("FAIL wrap_busy_len i=%0d got=%0d exp=40", i, n); end
      checks++;
      if (top_row !== 5'((i + 1) % 24)) begin
        failures++; $display("FAIL wrap_top_row i=%0d got=%0d exp=%0d", i, top_row, (i + 1) % 24);
      end
    end
    read_cell(3, 7, d);
    checks++; if (d !== BLANK) begin failures++; $display("FAIL wrap_cell_3_7 got=%h exp=20", d); end
    read_cell(10, 39, d);
    checks++; if (d !== BLANK) begin failures++; $display("FAIL wrap_cell_10_39 got=%h exp=20", d); end
    read_cell(0, 0, d);
    checks++; if (d !== BLANK) begin failures++; $display("FAIL wrap_cell_0_0 got=%h exp=20", d); end
    $display("test_scroll_wrap done");
  endtask

  task automatic test_clear;
    logic [5:0] d;
    int n;
    for (int r = 0; r < 24; r++) write_cell(r, r, 6'(r + 1));
    write_cell(23, 39, 6'h3F);
    write_cell(5, 5, 6'h33);
    pulse_scroll;
    count_busy(-1, -1, n);
    w_row = 5'd5; w_col = 6'd5; din = 6'h11;
    pulse_clear;
    count_busy(300, -1, n);
    checks++; if (n != 960) begin failures++; $display("FAIL clear_busy_len got=%0d exp=960", n); end
    checks++; if (top_row !== 5'd0) begin failures++; $display("FAIL clear_top_row got=%0d exp=0", top_row); end
    for (int p = 0; p < 960; p++) begin
      read_cell(p / 40, p % 40, d);
      checks++; if (d !== BLANK) begin failures++; $display("FAIL clear_cell p=%0d got=%h exp=20", p, d); end
    end
    $display("test_clear done");
  endtask

  task automatic test_clr_priority;
    logic [5:0] d;
    int n;
    pulse_scroll;
    count_busy(-1, -1, n);
    write_cell(2, 3, 6'h2B);
    scroll_req = 1'b1; clr_req = 1'b1;
    tick;
    scroll_req = 1'b0; clr_req = 1'b0;
    count_busy(-1, 10, n);
    checks++; if (n != 960) begin failures++; $display("FAIL prio_busy_len got=%0d exp=960", n); end
    checks++; if (top_row !== 5'd0) begin failures++; $display("FAIL prio_top_row got=%0d exp=0", top_row); end
    tick; tick;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL prio_no_queue got=%b exp=0", busy); end
    checks++; if (top_row !== 5'd0) begin failures++; $display("FAIL prio_top_row_after got=%0d exp=0", top_row); end
    read_cell(2, 3, d);
    checks++; if (d !== BLANK) begin failures++; $display("FAIL prio_cell got=%h exp=20", d); end
    $display("test_clr_priority done");
  endtask

  task automatic test_reset_mid_clear;
    logic [5:0] d;
    int n;
    write_cell(1, 10, 6'h15);
    write_cell(2, 19, 6'h18);
    write_cell(2, 20, 6'h17);
    write_cell(3, 30, 6'h16);
    read_cell(1, 10, d);
    checks++; if (d !== 6'h15) begin failures++; $display("FAIL mid_preread got=%h exp=15", d); end
    pulse_clear;
    n = 0;
    while (busy === 1'b1 && n < 100) begin tick; n++; end
    checks++; if (n != 100) begin failures++; $display("FAIL mid_busy_cycles got=%0d exp=100", n); end
    rst_n = 1'b0;
    tick;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    checks++; if (top_row !== 5'd0) begin failures++; $display("FAIL mid_top_row got=%0d exp=0", top_row); end
    checks++; if (dout !== 6'h00) begin failures++; $display("FAIL mid_dout got=%h exp=00", dout); end
    rst_n = 1'b1;
    tick;
    read_cell(0, 0, d);
    checks++; if (d !== BLANK) begin failures++; $display("FAIL mid_cell0 got=%h exp=20", d); end
    read_cell(1, 10, d);
    checks++; if (d !== BLANK) begin failures++; $display("FAIL mid_cell50 got=%h exp=20", d); end
    read_cell(2, 19, d);
    checks++; if (d !== BLANK) begin failures++; $display("FAIL mid_cell99 got=%h exp=20", d); end
    read_cell(2, 20, d);
    checks++; if (d !== 6'h17) begin failures++; $display("FAIL mid_cell100 got=%h exp=17", d); end
    read_cell(3, 30, d);
    checks++; if (d !== 6'h16) begin failures++; $display("FAIL mid_cell150 got=%h exp=16", d); end
    $display("test_reset_mid_clear done");
  endtask

  initial begin
    test_reset;
    test_read_write;
    test_scroll;
    test_scroll_wrap;
    test_clear;
    test_clr_priority;
    test_reset_mid_clear;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
